// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
//   Shared definitions for the player-sprite controller:
//   - USB HID keycodes recognised by the key decoder (0x00 marks an empty slot)
//   - life-cycle state enum
//   - clamp helper used by the movement datapath
// -----------------------------------------------------------------------------
package player_pkg;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } player_state_e;

  // Saturate a signed candidate coordinate into [lo, hi]. Signed arithmetic
  // keeps a step below zero from wrapping to a large unsigned value.
  function automatic logic [9:0] clamp_axis(input logic signed [10:0] v,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
    logic signed [10:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    return r[9:0];
  endfunction

endpackage

// File: rtl/player_ctrl_aabb_hit.sv
// -----------------------------------------------------------------------------
// aabb_hit
//   Combinational axis-aligned overlap test of one enemy box against the
//   player sprite box. Edges that merely touch do not count as a hit.
//   Ports:
//     cx_i, cy_i   sprite centre
//     ex_i, ey_i   enemy top-left corner
//     size_i       enemy side length
//     alive_i      enemy valid; an invalid enemy never hits
//     hit_o        overlap flag
// -----------------------------------------------------------------------------
module aabb_hit
  import player_pkg::*;
#(
  parameter int HALF_W = 17,
  parameter int HALF_H = 16
) (
  input  logic [9:0] cx_i,
  input  logic [9:0] cy_i,
  input  logic [9:0] ex_i,
  input  logic [9:0] ey_i,
  input  logic [9:0] size_i,
  input  logic       alive_i,
  output logic       hit_o
);

  localparam logic signed [11:0] HW = 12'(HALF_W);
  localparam logic signed [11:0] HH = 12'(HALF_H);

  // 12-bit signed: holds ex+size up to 2046 and a sprite edge below zero.
  logic signed [11:0] cx, cy, ex, ey, sz;

  assign cx = $signed({2'b00, cx_i});
  assign cy = $signed({2'b00, cy_i});
  assign ex = $signed({2'b00, ex_i});
  assign ey = $signed({2'b00, ey_i});
  assign sz = $signed({2'b00, size_i});

  assign hit_o = alive_i
              && ((cx - HW) < (ex + sz))
              && ((cx + HW) > ex)
              && ((cy - HH) < (ey + sz))
              && ((cy + HH) > ey);

endmodule

// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
//   Player-sprite controller. Once per frame_clk edge the sprite moves from
//   the scanned keycodes (diagonals allowed, hard clamp at the play field),
//   is tested against N_ENEMY enemy boxes, and a lives / respawn /
//   invulnerability / game-over state machine advances.
//   Ports:
//     frame_clk    frame-rate clock
//     Reset        asynchronous active-low reset
//     keycode      KEY_SLOTS packed 8-bit keycodes, slot k = [8k+7:8k]
//     enemy_x/y    packed enemy top-left corners, enemy i = [10i+9:10i]
//     enemy_size   packed enemy side lengths
//     enemy_alive  per-enemy valid
//     BallX/BallY  sprite centre
//     Ball_W/H     sprite half-extents (constant)
//     Ball_die     one-cycle pulse per life lost
//     Hit_idx      lowest enemy index of the last hit taken
//     Lives        remaining lives
//     Invuln       high while invulnerable
//     Blink        sprite-blink enable
//     Game_over    high when out of lives
//     dbg_state_o  current FSM state
// -----------------------------------------------------------------------------
module player_ctrl
  import player_pkg::*;
#(
  parameter int N_ENEMY       = 4,
  parameter int KEY_SLOTS     = 3,
  parameter int STEP          = 3,
  parameter int HALF_W        = 17,
  parameter int HALF_H        = 16,
  parameter int X_MIN         = 3,
  parameter int X_MAX         = 636,
  parameter int Y_MIN         = 3,
  parameter int Y_MAX         = 476,
  parameter int SPAWN_X       = 320,
  parameter int SPAWN_Y       = 450,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  localparam int IDX_W        = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic [10*N_ENEMY-1:0]  enemy_x,
  input  logic [10*N_ENEMY-1:0]  enemy_y,
  input  logic [10*N_ENEMY-1:0]  enemy_size,
  input  logic [N_ENEMY-1:0]     enemy_alive,
  output logic [9:0]             BallX,
  output logic [9:0]             BallY,
  output logic [9:0]             Ball_W,
  output logic [9:0]             Ball_H,
  output logic                   Ball_die,
  output logic [IDX_W-1:0]       Hit_idx,
  output logic [2:0]             Lives,
  output logic                   Invuln,
  output logic                   Blink,
  output logic                   Game_over,
  output logic [1:0]             dbg_state_o
);

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_LO   = 11'(X_MIN + HALF_W);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - HALF_W);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN + HALF_H);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - HALF_H);
  localparam logic [9:0]         SPX    = 10'(SPAWN_X);
  localparam logic [9:0]         SPY    = 10'(SPAWN_Y);
  localparam logic [2:0]         LIVES0 = 3'(LIVES);
  localparam logic [7:0]         INV0   = 8'(INVULN_FRAMES);

  player_state_e    state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       lives_q, lives_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             die_q, die_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // ---------------------------------------------------------------------------
  // Key decode: any slot may carry any key; empty slots (0x00) match nothing.
  // ---------------------------------------------------------------------------
  logic key_a, key_d, key_w, key_s, key_enter;

  always_comb begin
    key_a     = 1'b0;
    key_d     = 1'b0;
    key_w     = 1'b0;
    key_s     = 1'b0;
    key_enter = 1'b0;
    for (int k = 0; k < KEY_SLOTS; k++) begin
      if (keycode[8*k +: 8] == KEY_A)     key_a     = 1'b1;
      if (keycode[8*k +: 8] == KEY_D)     key_d     = 1'b1;
      if (keycode[8*k +: 8] == KEY_W)     key_w     = 1'b1;
      if (keycode[8*k +: 8] == KEY_S)     key_s     = 1'b1;
      if (keycode[8*k +: 8] == KEY_ENTER) key_enter = 1'b1;
    end
  end

  // Opposing keys cancel; no motion register, so release stops immediately.
  logic signed [10:0] dx, dy;
  logic [9:0]         x_mov, y_mov;

  always_comb begin
    dx = '0;
    dy = '0;
    if (key_a && !key_d) dx = -STEP_S;
    if (key_d && !key_a) dx =  STEP_S;
    if (key_w && !key_s) dy = -STEP_S;
    if (key_s && !key_w) dy =  STEP_S;
    x_mov = clamp_axis($signed({1'b0, x_q}) + dx, X_LO, X_HI);
    y_mov = clamp_axis($signed({1'b0, y_q}) + dy, Y_LO, Y_HI);
  end

  // ---------------------------------------------------------------------------
  // Overlap against every enemy, from the registered position.
  // ---------------------------------------------------------------------------
  logic [N_ENEMY-1:0] hit_vec;
  logic               any_hit;
  logic [IDX_W-1:0]   hit_idx;

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_hit
    aabb_hit #(
      .HALF_W (HALF_W),
      .HALF_H (HALF_H)
    ) u_aabb_hit (
      .cx_i    (x_q),
      .cy_i    (y_q),
      .ex_i    (enemy_x[10*g +: 10]),
      .ey_i    (enemy_y[10*g +: 10]),
      .size_i  (enemy_size[10*g +: 10]),
      .alive_i (enemy_alive[g]),
      .hit_o   (hit_vec[g])
    );
  end

  // Scan downward so the lowest hitting index wins.
  always_comb begin
    any_hit = |hit_vec;
    hit_idx = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Life-cycle FSM: next state and datapath updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    die_d   = 1'b0;
    idx_d   = idx_q;

    unique case (state_q)
      ALIVE: begin
        if (any_hit) begin
          // Several simultaneous overlaps still cost a single life; the
          // sprite does not move on the hit cycle.
          die_d = 1'b1;
          idx_d = hit_idx;
          if (lives_q <= 3'd1) begin
            lives_d = 3'd0;
            state_d = DEAD;
          end else begin
            lives_d = lives_q - 3'd1;
            x_d     = SPX;
            y_d     = SPY;
            if (INVULN_FRAMES == 0) begin
              state_d = ALIVE;
              cnt_d   = 8'd0;
            end else begin
              state_d = INVULN;
              cnt_d   = INV0;
            end
          end
        end else begin
          x_d = x_mov;
          y_d = y_mov;
        end
      end

      INVULN: begin
        x_d = x_mov;
        y_d = y_mov;
        if (cnt_q <= 8'd1) begin
          state_d = ALIVE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      DEAD: begin
        if (key_enter) begin
          lives_d = LIVES0;
          x_d     = SPX;
          y_d     = SPY;
          if (INVULN_FRAMES == 0) begin
            state_d = ALIVE;
            cnt_d   = 8'd0;
          end else begin
            state_d = INVULN;
            cnt_d   = INV0;
          end
        end
      end

      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ALIVE;
      x_q     <= SPX;
      y_q     <= SPY;
      lives_q <= LIVES0;
      cnt_q   <= 8'd0;
      die_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      die_q   <= die_d;
      idx_q   <= idx_d;
    end
  end

  assign BallX       = x_q;
  assign BallY       = y_q;
  assign Ball_W      = 10'(HALF_W);
  assign Ball_H      = 10'(HALF_H);
  assign Ball_die    = die_q;
  assign Hit_idx     = idx_q;
  assign Lives       = lives_q;
  assign Invuln      = (state_q == INVULN);
  assign Blink       = (state_q == INVULN) ? cnt_q[3] : 1'b1;
  assign Game_over   = (state_q == DEAD);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_player_ctrl.sv
module tb_player_ctrl;

  localparam int N  = 4;
  localparam int KS = 3;
  localparam int STEP = 3;
  localparam int HW = 17, HH = 16;
  localparam int XLO = 3 + 17, XHI = 636 - 17;
  localparam int YLO = 3 + 16, YHI = 476 - 16;
  localparam int SPX = 320, SPY = 450;
  localparam int LIVES0 = 3;
  localparam int INVF = 120;

  // ---------------- clock / reset ----------------
  logic frame_clk = 1'b0;
  logic Reset     = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic [8*KS-1:0] keycode     = '0;
  logic [10*N-1:0] enemy_x     = '0;
  logic [10*N-1:0] enemy_y     = '0;
  logic [10*N-1:0] enemy_size  = '0;
  logic [N-1:0]    enemy_alive = '0;
  logic [9:0] BallX, BallY, Ball_W, Ball_H;
  logic       Ball_die, Invuln, Blink, Game_over;
  logic [1:0] Hit_idx;
  logic [2:0] Lives;
  logic [1:0] dbg_state;

  player_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .enemy_size  (enemy_size),
    .enemy_alive (enemy_alive),
    .BallX       (BallX),
    .BallY       (BallY),
    .Ball_W      (Ball_W),
    .Ball_H      (Ball_H),
    .Ball_die    (Ball_die),
    .Hit_idx     (Hit_idx),
    .Lives       (Lives),
    .Invuln      (Invuln),
    .Blink       (Blink),
    .Game_over   (Game_over),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Game phase: 0 playing, 1 protected after respawn, 2 out of lives.
  int m_x, m_y, m_lives, m_phase, m_left, m_die, m_idx;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_x = SPX; m_y = SPY; m_lives = LIVES0; m_phase = 0;
    m_left = 0; m_die = 0; m_idx = 0;
  endtask

  task automatic begin_protection();
    m_x = SPX; m_y = SPY;
    if (INVF == 0) begin m_phase = 0; m_left = 0; end
    else begin m_phase = 1; m_left = INVF; end
  endtask

  // One frame of game rules applied to the inputs currently being driven.
  task automatic model_step();
    bit a, d, w, s, ent;
    int dx, dy, first;
    a = 0; d = 0; w = 0; s = 0; ent = 0;
    for (int k = 0; k < KS; k++) begin
      case (keycode[8*k +: 8])
        8'h04: a = 1;
        8'h07: d = 1;
        8'h1A: w = 1;
        8'h16: s = 1;
        8'h28: ent = 1;
        default: ;
      endcase
    end
    dx = (d ? STEP : 0) - (a ? STEP : 0);
    dy = (s ? STEP : 0) - (w ? STEP : 0);
    first = -1;
    for (int i = N - 1; i >= 0; i--) begin
      int ex, ey, sz;
      ex = int'(enemy_x[10*i +: 10]);
      ey = int'(enemy_y[10*i +: 10]);
      sz = int'(enemy_size[10*i +: 10]);
      if (enemy_alive[i] && (m_x - HW < ex + sz) && (m_x + HW > ex) &&
          (m_y - HH < ey + sz) && (m_y + HH > ey))
        first = i;
    end
    m_die = 0;
    if (m_phase == 0) begin
      if (first >= 0) begin
        m_die = 1;
        m_idx = first;
        m_lives = m_lives - 1;
        if (m_lives == 0) m_phase = 2;
        else begin_protection();
      end else begin
        m_x = clampi(m_x + dx, XLO, XHI);
        m_y = clampi(m_y + dy, YLO, YHI);
      end
    end else if (m_phase == 1) begin
      m_x = clampi(m_x + dx, XLO, XHI);
      m_y = clampi(m_y + dy, YLO, YHI);
      m_left = m_left - 1;
      if (m_left <= 0) begin m_phase = 0; m_left = 0; end
    end else if (ent) begin
      m_lives = LIVES0;
      begin_protection();
    end
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"},      int'(BallX), m_x);
    check({tag, ".y"},      int'(BallY), m_y);
    check({tag, ".lives"},  int'(Lives), m_lives);
    check({tag, ".die"},    int'(Ball_die), m_die);
    check({tag, ".idx"},    int'(Hit_idx), m_idx);
    check({tag, ".inv"},    int'(Invuln), (m_phase == 1) ? 1 : 0);
    check({tag, ".blink"},  int'(Blink), (m_phase == 1) ? ((m_left / 8) % 2) : 1);
    check({tag, ".gover"},  int'(Game_over), (m_phase == 2) ? 1 : 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    model_step();
    @(posedge frame_clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input bit immediate);
    Reset = 1'b0;
    model_reset();
    if (immediate) begin
      #2;
      check_all("rst_async");
    end
    @(posedge frame_clk);
    #1;
    check_all("rst");
    Reset = 1'b1;
  endtask

  task automatic set_keys(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    keycode = {k2, k1, k0};
  endtask

  task automatic set_enemy(input int i, input int x, input int y, input int sz, input bit alive);
    enemy_x[10*i +: 10]    = 10'(x);
    enemy_y[10*i +: 10]    = 10'(y);
    enemy_size[10*i +: 10] = 10'(sz);
    enemy_alive[i]         = alive;
  endtask

  task automatic clear_enemies();
    enemy_x = '0; enemy_y = '0; enemy_size = '0; enemy_alive = '0;
  endtask

  // Step until protection ends (bounded) and return how many protected samples were seen.
  task automatic run_protection(output int seen);
    int guard;
    seen = Invuln ? 1 : 0;
    guard = 0;
    while (Invuln && guard < 400) begin
      step("prot");
      if (Invuln) seen++;
      guard++;
    end
    if (guard >= 400) begin
      checks++;
      errors++;
      $error("FAIL prot_timeout observed=%0d expected<400", guard);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int seen, frozen_x, frozen_y;
    logic [7:0] pool [7];

    // Reset state
    do_reset(1'b0);
    check("ball_w", int'(Ball_W), HW);
    check("ball_h", int'(Ball_H), HH);
    step("idle");
    check("idle_x", int'(BallX), 320);
    check("idle_y", int'(BallY), 450);

    // Hold D in slot 2 up to the right limit
    set_keys(8'h00, 8'h00, 8'h07);
    step("d1");
    check("d1_x", int'(BallX), 323);
    repeat (199) step("d_hold");
    check("d_limit", int'(BallX), 619);
    set_keys(8'h04, 8'h00, 8'h07);
    repeat (3) step("ad");
    check("ad_x", int'(BallX), 619);

    // W+A diagonal, then W to the top limit
    do_reset(1'b1);
    set_keys(8'h1A, 8'h04, 8'h00);
    step("wa");
    check("wa_x", int'(BallX), 317);
    check("wa_y", int'(BallY), 447);
    set_keys(8'h00, 8'h1A, 8'h00);
    repeat (160) step("w_hold");
    check("w_limit", int'(BallY), 19);
    set_keys(8'h00, 8'h00, 8'h00);
    step("release");

    // Edge touching and dead enemies do not hit
    do_reset(1'b0);
    set_enemy(0, 337, 440, 20, 1'b1);   // left edge on sprite right edge
    set_enemy(1, 283, 440, 20, 1'b1);   // right edge on sprite left edge
    set_enemy(2, 310, 440, 20, 1'b0);   // overlapping but not alive
    set_enemy(3, 320, 466, 20, 1'b1);   // top edge on sprite bottom edge
    repeat (2) step("touch");
    check("touch_lives", int'(Lives), 3);
    set_enemy(3, 336, 440, 20, 1'b1);   // one pixel inside
    step("inside");
    check("inside_die", int'(Ball_die), 1);
    check("inside_idx", int'(Hit_idx), 3);
    // Reset while protected returns to the reset state immediately
    repeat (10) step("prot_pre_rst");
    clear_enemies();
    do_reset(1'b1);

    // Three enemies overlapping at spawn: one life per hit, lowest index
    set_enemy(0, 310, 440, 20, 1'b1);
    set_enemy(1, 300, 430, 30, 1'b1);
    set_enemy(2, 330, 440, 20, 1'b1);
    for (int h = 1; h <= 3; h++) begin
      step("hit");
      check("hit_die", int'(Ball_die), 1);
      check("hit_idx", int'(Hit_idx), 0);
      check("hit_lives", int'(Lives), 3 - h);
      if (h < 3) begin
        check("hit_x", int'(BallX), 320);
        run_protection(seen);
        check("prot_len", seen, INVF);
      end
    end
    check("dead_gover", int'(Game_over), 1);
    frozen_x = int'(BallX);
    frozen_y = int'(BallY);
    set_keys(8'h07, 8'h16, 8'h00);
    repeat (5) step("dead_keys");
    check("dead_x", int'(BallX), frozen_x);
    check("dead_y", int'(BallY), frozen_y);
    set_keys(8'h00, 8'h28, 8'h00);
    step("restart");
    check("restart_lives", int'(Lives), 3);
    check("restart_inv", int'(Invuln), 1);
    check("restart_x", int'(BallX), 320);
    check("restart_y", int'(BallY), 450);
    set_keys(8'h28, 8'h00, 8'h00);
    step("enter_ignored");
    clear_enemies();

    // Random phase: random keys, enemies placed near the sprite
    pool[0] = 8'h00; pool[1] = 8'h04; pool[2] = 8'h07; pool[3] = 8'h1A;
    pool[4] = 8'h16; pool[5] = 8'h28; pool[6] = 8'h55;
    for (int f = 0; f < 500; f++) begin
      set_keys(pool[$urandom_range(0, 6)], pool[$urandom_range(0, 6)], pool[$urandom_range(0, 6)]);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++)
          set_enemy(i, clampi(m_x - 60 + int'($urandom_range(0, 80)), 0, 1000),
                       clampi(m_y - 60 + int'($urandom_range(0, 80)), 0, 1000),
                       int'($urandom_range(1, 30)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 1) == 0) begin
        clear_enemies();
      end
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
Parametrised player-sprite controller that succeeds the single-ball mover.
- Moves the player sprite one frame per frame_clk from up to KEY_SLOTS USB keycodes, with diagonal motion and hard clamping at the play-field edges.
- Tests axis-aligned overlap against N_ENEMY meteor boxes and runs a lives / respawn / invulnerability / game-over state machine.
- Sits between the USB keycode register and the sprite renderer / score logic.

Parameters:
N_ENEMY, 4, number of enemy boxes checked per frame
KEY_SLOTS, 3, number of 8-bit keycode slots scanned
STEP, 3, pixels moved per frame per axis
HALF_W, 17, sprite half-width (centre to left/right edge)
HALF_H, 16, sprite half-height (centre to top/bottom edge)
X_MIN / X_MAX, 3 / 636, play-field horizontal limits
Y_MIN / Y_MAX, 3 / 476, play-field vertical limits
SPAWN_X / SPAWN_Y, 320 / 450, reset and respawn centre
LIVES, 3, starting lives (1..7)
INVULN_FRAMES, 120, frames of post-respawn invulnerability (max 255)

Ports:
frame_clk  in  1  frame-rate clock, single clock domain
Reset  in  1  asynchronous, active-low reset (asserted at 0)
keycode  in  8*KEY_SLOTS  packed keycodes; slot k = keycode[8k+7:8k]
enemy_x, enemy_y, enemy_size  in  10 x N_ENEMY  enemy box top-left corner and side length
enemy_alive  in  N_ENEMY  per-enemy valid
BallX, BallY  out  10  sprite centre
Ball_W, Ball_H  out  10  constant HALF_W, HALF_H
Ball_die  out  1  one-cycle pulse on each life lost
Hit_idx  out  clog2(N_ENEMY)  lowest-index enemy that caused the last hit
Lives  out  3  remaining lives
Invuln  out  1  high while invulnerable
Blink  out  1  sprite-blink enable; counter bit 3 while invulnerable, else 1
Game_over  out  1  high in DEAD

Behaviour:
- Reset low (async) → BallX=SPAWN_X, BallY=SPAWN_Y, Lives=LIVES, state=ALIVE, Ball_die=0, Hit_idx=0, Invuln=0, Blink=1, Game_over=0, invulnerability counter=0.
- Key decode, any slot matching:
  - A=0x04 → dx=-STEP; D=0x07 → dx=+STEP; A and D both present → dx=0.
  - W=0x1A → dy=-STEP; S=0x16 → dy=+STEP; W and S both present → dy=0.
  - Enter=0x28 → restart request.
  - 0x00 is an empty slot.
- Movement is applied in the same frame: next X = clamp(X+dx, X_MIN+HALF_W, X_MAX-HALF_W), computed in 11-bit signed to prevent wrap below 0. Y is handled the same way with the Y limits.
  - There is no motion register, so a key release stops the sprite on the next edge.
  - At a limit the sprite stays exactly on the limit and never overshoots.
- Overlap, combinational from the current registered position, per enemy i with enemy_alive[i]=1:
  - (X-HALF_W) < ex+size and (X+HALF_W) > ex and (Y-HALF_H) < ey+size and (Y+HALF_H) > ey.
  - Touching edges are not a hit.
  - any_hit = OR over all i. Hit_idx = lowest i that hits, registered when the hit is taken.
- FSM, evaluated each frame_clk edge:
  - ALIVE: move. If any_hit: Ball_die=1 for this cycle, Lives-1.
    - If Lives was 1 → DEAD, Lives=0.
    - Otherwise → INVULN, position set to SPAWN, counter=INVULN_FRAMES.
    - Position update is suppressed on a hit cycle.
  - INVULN: move; hits ignored; counter decrements. Counter==1 on an edge → ALIVE next cycle.
    - INVULN_FRAMES=0 → go straight to ALIVE.
  - DEAD: position frozen, Game_over=1, hits ignored.
    - On restart request → INVULN, Lives=LIVES, position=SPAWN, counter=INVULN_FRAMES.
- Restart is ignored outside DEAD.
- Simultaneous hits from several enemies cost exactly one life.
- Reset asserted mid-INVULN or DEAD returns to the reset state immediately.

Decomposition:
- player_pkg: keycode constants (KEY_A, KEY_D, KEY_W, KEY_S, KEY_ENTER) and state enum ALIVE / INVULN / DEAD.
- Sub-module aabb_hit: combinational overlap of one enemy box against the sprite box; instantiated N_ENEMY times with a generate loop.

Test Plan:
- Reset low then high, no keys → BallX=320, BallY=450, Lives=3, Game_over=0, Blink=1.
- Hold D (0x07 in slot 2) for 200 frames from X=320 → X advances 3 per frame and stops at exactly 619; then A+D together → X unchanged.
- Press W+A together from (320,450) for 1 frame → (317,447); hold W until the top → Y saturates at 19.
- Enemy 2 at (330,440), size 20, alive; enemies 0 and 1 overlapping at the same time → single Ball_die pulse, Hit_idx=0, Lives=2, position (320,450), Invuln=1 for 120 frames, then ALIVE.
- Three hits, each after invulnerability ends → third hit gives Lives=0 and Game_over=1, and the position ignores keys; Enter → Lives=3, INVULN, position at spawn.
- Enemy overlapping with enemy_alive=0, or box just touching the sprite edge (ex = X+HALF_W) → no hit.
